rot_pipe: RTL and testbench

//  Registered, flow-controlled wrapper around the combinational rot barrel rotator.

---
 rtl/rot_pipe_pkg.sv | 12 +
 rtl/rot_pipe_rot.sv | 26 ++
 rtl/rot_pipe.sv | 128 ++++++++++++
 tb/tb_rot_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pipe_pkg.sv
// Shared defaults and configuration checks for the rot_pipe slice.
package rot_pipe_pkg;

   localparam int ROT_N_DEF      = 64;
   localparam int ROT_LOG2_N_DEF = 6;
   localparam int ROT_TAG_W_DEF  = 4;

   function automatic bit rot_n_ok(input int n, input int log2_n);
      return n == (1 << log2_n);
   endfunction

endpackage

// File: rtl/rot_pipe_rot.sv
// Combinational barrel rotator: o = i rotated right (toward higher index) by k.
// Vectors are ascending, so index 0 is the MSB and k[0] carries weight N/2.
module rot #(
   parameter int N      = rot_pipe_pkg::ROT_N_DEF,
   parameter int log2_N = rot_pipe_pkg::ROT_LOG2_N_DEF
) (
   input  logic [0:N-1]      i,
   input  logic [0:log2_N-1] k,
   output logic [0:N-1]      o
);

   logic [0:N-1] stg [0:log2_N];

   assign stg[0] = i;

   for (genvar s = 0; s < log2_N; s++) begin : g_stage
      localparam int SH = N >> (s + 1);
      logic [0:N-1] rotated;
      // The low SH bits wrap around to the top.
      assign rotated    = {stg[s][N-SH +: SH], stg[s][0 +: N-SH]};
      assign stg[s + 1] = k[s] ? rotated : stg[s];
   end

   assign o = stg[log2_N];

endmodule

// File: rtl/rot_pipe.sv
// Two-stage valid/ready wrapper around the rot barrel rotator (A: operands, B: result).
// Optional feature macro: ROT_PIPE_LEFT_EN adds s_dir for left rotation.
module rot_pipe
   import rot_pipe_pkg::*;
#(
   parameter int N      = ROT_N_DEF,
   parameter int LOG2_N = ROT_LOG2_N_DEF,
   parameter int TAG_W  = ROT_TAG_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [0:N-1]      s_bits,
   input  logic [0:LOG2_N-1] s_k,
`ifdef ROT_PIPE_LEFT_EN
   input  logic              s_dir,
`endif
   input  logic [TAG_W-1:0]  s_tag,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [0:N-1]      m_bits,
   output logic [TAG_W-1:0]  m_tag,
   output logic [31:0]       ops_done
);

   if (!rot_n_ok(N, LOG2_N)) begin : g_bad_cfg
      $error("rot_pipe: N must equal 2**LOG2_N");
   end

   logic              a_valid_q, a_valid_d;
   logic [0:N-1]      a_bits_q, a_bits_d;
   logic [LOG2_N-1:0] a_k_q, a_k_d;
   logic [TAG_W-1:0]  a_tag_q, a_tag_d;
   logic              m_valid_q, m_valid_d;
   logic [0:N-1]      m_bits_q, m_bits_d;
   logic [TAG_W-1:0]  m_tag_q, m_tag_d;
   logic [31:0]       ops_done_q, ops_done_d;

   logic              b_adv, a_adv, s_fire, m_fire;
   logic [LOG2_N-1:0] rot_k;
   logic [0:N-1]      rot_o;

   assign b_adv   = !m_valid_q | m_ready;
   assign a_adv   = a_valid_q & b_adv;
   assign s_ready = !a_valid_q | b_adv;
   assign s_fire  = s_valid & s_ready;
   assign m_fire  = m_valid_q & m_ready;

`ifdef ROT_PIPE_LEFT_EN
   logic a_dir_q, a_dir_d;

   always_comb begin
      a_dir_d = s_fire ? s_dir : a_dir_q;
      // Left by k == right by (N - k) mod N; LOG2_N-bit wrap maps k=0 to 0.
      rot_k   = a_dir_q ? (LOG2_N'(0) - a_k_q) : a_k_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) a_dir_q <= 1'b0;
      else        a_dir_q <= a_dir_d;
   end
`else
   assign rot_k = a_k_q;
`endif

   rot #(.N(N), .log2_N(LOG2_N)) u_rot (
      .i (a_bits_q),
      .k (rot_k),
      .o (rot_o)
   );

   always_comb begin
      a_valid_d  = a_valid_q;
      a_bits_d   = a_bits_q;
      a_k_d      = a_k_q;
      a_tag_d    = a_tag_q;
      m_valid_d  = m_valid_q;
      m_bits_d   = m_bits_q;
      m_tag_d    = m_tag_q;
      ops_done_d = ops_done_q + 32'(m_fire);

      if (s_fire) begin
         a_valid_d = 1'b1;
         a_bits_d  = s_bits;
         a_k_d     = s_k;
         a_tag_d   = s_tag;
      end else if (a_adv) begin
         a_valid_d = 1'b0;
      end

      if (a_adv) begin
         m_valid_d = 1'b1;
         m_bits_d  = rot_o;
         m_tag_d   = a_tag_q;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q  <= 1'b0;
         a_bits_q   <= '0;
         a_k_q      <= '0;
         a_tag_q    <= '0;
         m_valid_q  <= 1'b0;
         m_bits_q   <= '0;
         m_tag_q    <= '0;
         ops_done_q <= '0;
      end else begin
         a_valid_q  <= a_valid_d;
         a_bits_q   <= a_bits_d;
         a_k_q      <= a_k_d;
         a_tag_q    <= a_tag_d;
         m_valid_q  <= m_valid_d;
         m_bits_q   <= m_bits_d;
         m_tag_q    <= m_tag_d;
         ops_done_q <= ops_done_d;
      end
   end

   assign m_valid  = m_valid_q;
   assign m_bits   = m_bits_q;
   assign m_tag    = m_tag_q;
   assign ops_done = ops_done_q;

endmodule

// File: tb/tb_rot_pipe.sv
// Randomised and directed bench for rot_pipe (N=64) with a queue-based reference model.
module tb_rot_pipe;

   localparam int N = 64;
   localparam int LOG2_N = 6;
   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [0:N-1]      s_bits = '0;
   logic [0:LOG2_N-1] s_k = '0;
   logic              s_dir = 1'b0;
   logic [TAG_W-1:0]  s_tag = '0;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [0:N-1]      m_bits;
   logic [TAG_W-1:0]  m_tag;
   logic [31:0]       ops_done;

   int tests = 0;
   int fails = 0;

   rot_pipe #(.N(N), .LOG2_N(LOG2_N), .TAG_W(TAG_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_bits   (s_bits),
      .s_k      (s_k),
`ifdef ROT_PIPE_LEFT_EN
      .s_dir    (s_dir),
`endif
      .s_tag    (s_tag),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_bits   (m_bits),
      .m_tag    (m_tag),
      .ops_done (ops_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Plain integer rotate; left rotation expressed as the equivalent right amount.
   function automatic logic [63:0] model_rot(input logic [63:0] x, input int k, input bit left);
      int amt;
      amt = left ? ((N - k) % N) : k;
      if (amt == 0) return x;
      return (x >> amt) | (x << (N - amt));
   endfunction

   typedef struct {
      logic [63:0]      bits;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   exp_ops = 0;
   bit   held = 1'b0;
   logic [63:0] held_bits;
   logic [TAG_W-1:0] held_tag;

   // Compare process: inputs change just after posedge, so negedge sees the
   // values the next posedge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_ops = 0;
         held = 1'b0;
      end else begin
         exp_t e;
         bit left;
         chk("s_ready_rule", 64'(s_ready), 64'(!(exp_q.size() == 2 && !m_ready)));
         chk("ops_done", 64'(ops_done), 64'(exp_ops));
         if (held) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_bits", m_bits, held_bits);
            chk("hold_tag", 64'(m_tag), 64'(held_tag));
         end
         held = m_valid && !m_ready;
         held_bits = m_bits;
         held_tag = m_tag;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_output: got %h expected none", m_bits);
            end else begin
               e = exp_q.pop_front();
               chk("stream_bits", m_bits, e.bits);
               chk("stream_tag", 64'(m_tag), 64'(e.tag));
            end
            exp_ops++;
         end
         if (s_valid && s_ready) begin
`ifdef ROT_PIPE_LEFT_EN
            left = s_dir;
`else
            left = 1'b0;
`endif
            e.bits = model_rot(s_bits, int'(s_k), left);
            e.tag = s_tag;
            exp_q.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic offer_one(input logic [63:0] b, input int k, input logic [TAG_W-1:0] t);
      s_valid = 1'b1; s_bits = b; s_k = LOG2_N'(k); s_tag = t;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Single word through an empty pipe, checking the 2-clock latency.
   task automatic single(input string nm, input logic [63:0] b, input int k, input logic [63:0] exp);
      m_ready = 1'b1;
      offer_one(b, k, 4'h5);
      chk({nm, "_lat1"}, 64'(m_valid), 64'd0);
      tick();
      chk({nm, "_valid"}, 64'(m_valid), 64'd1);
      chk({nm, "_bits"}, m_bits, exp);
      chk({nm, "_tag"}, 64'(m_tag), 64'h5);
      tick();
   endtask

   initial begin
      int accepted, cyc, ops0;
      logic [63:0] w [3];
      bit acc;

      #2;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_bits", m_bits, 64'd0);
      chk("rst_m_tag", 64'(m_tag), 64'd0);
      chk("rst_ops_done", 64'(ops_done), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd1);
      do_reset();

      single("msb_lsb_k1", 64'h8000_0000_0000_0001, 1, 64'hC000_0000_0000_0000);
      single("swap_k32", 64'h0123_4567_89AB_CDEF, 32, 64'h89AB_CDEF_0123_4567);
      single("pass_k0", 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF);
      single("k63", 64'h8000_0000_0000_0000, 63, 64'h0000_0000_0000_0001);
`ifdef ROT_PIPE_LEFT_EN
      s_dir = 1'b1;
      single("left_k4", 64'h0123_4567_89AB_CDEF, 4, 64'h1234_5678_9ABC_DEF0);
      single("left_k0", 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF);
      s_dir = 1'b0;
`endif

      // Random stream with random stalls.
      do_reset();
      accepted = 0;
      cyc = 0;
      while (accepted < 1000 && cyc < 20000) begin
         if (!s_valid || acc) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_bits = {$urandom, $urandom};
            s_k = LOG2_N'($urandom);
            s_tag = TAG_W'($urandom);
`ifdef ROT_PIPE_LEFT_EN
            s_dir = $urandom_range(0, 1) == 1;
`endif
         end
         m_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk); #1;
         if (acc) accepted++;
         cyc++;
      end
      s_valid = 1'b0;
      s_dir = 1'b0;
      m_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 50) begin tick(); cyc++; end
      tick();
      chk("stream_drained", 64'(exp_q.size()), 64'd0);
      chk("stream_ops_done", 64'(ops_done), 64'd1000);

      // Full stall: 3 words offered while the consumer is blocked.
      m_ready = 1'b0;
      w[0] = 64'h1111_2222_3333_4444;
      w[1] = 64'hFEDC_BA98_7654_3210;
      w[2] = 64'hA5A5_0000_FFFF_5A5A;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         s_valid = (accepted < 3);
         s_bits = w[accepted % 3];
         s_k = LOG2_N'(accepted * 8 + 4);
         s_tag = TAG_W'(accepted + 1);
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk); #1;
         if (acc) accepted++;
      end
      chk("stall_accepted", 64'(accepted), 64'd2);
      chk("stall_s_ready", 64'(s_ready), 64'd0);
      ops0 = int'(ops_done);
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_b2b_valid", 64'(m_valid), 64'd1);
         chk("stall_order", m_bits, model_rot(w[i], i * 8 + 4, 1'b0));
         chk("stall_tag", 64'(m_tag), 64'(i + 1));
         @(posedge clk); #1;
         s_valid = 1'b0;
      end
      tick();
      chk("stall_ops_done", 64'(ops_done), 64'(ops0 + 3));

      // Reset with both stages full.
      m_ready = 1'b0;
      offer_one(64'hDEAD_BEEF_0000_0001, 3, 4'h9);
      offer_one(64'hCAFE_F00D_0000_0002, 5, 4'hA);
      chk("pre_rst_full", 64'(s_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_m_valid", 64'(m_valid), 64'd0);
      chk("midrst_ops_done", 64'(ops_done), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_no_stale", 64'(m_valid), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
